// File: rtl/cycle_sequencer_if.sv
// Bundle between the micro-cycle sequencer and the instruction decoder /
// front panel. The sequencer takes the master modport; the decoder and
// panel side take the slave modport.
interface cycle_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic [3:0]         state;
    logic               run;
    logic               step_req;
    logic               step_ack;
    logic [3:0]         cycle;
    logic               retire;
    logic               halted;
    logic               fault;
    logic [COUNT_W-1:0] inst_count;

    modport master (
        input  state, run, step_req,
        output step_ack, cycle, retire, halted, fault, inst_count
    );

    modport slave (
        output state, run, step_req,
        input  step_ack, cycle, retire, halted, fault, inst_count
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Micro-cycle sequencer: steps the decoder's cycle index once per clock,
// restarts at instruction boundaries, freezes on HALT, traps on overrun,
// and counts retired instructions.
// Optional single-step handshake is compiled in when SEQ_STEP_EN is defined;
// without it step_req is ignored and step_ack is tied low.
// STATE_NEXT / STATE_HALT defaults must match the decoder's encodings.
module cycle_sequencer #(
    parameter int         MAX_CYCLE  = 7,
    parameter int         COUNT_W    = 16,
    parameter logic [3:0] STATE_NEXT = 4'hE,
    parameter logic [3:0] STATE_HALT = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cycle_sequencer_if.master     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fsm_t;

    localparam logic [3:0] LAST_CYCLE = 4'(MAX_CYCLE);

    fsm_t               fsm_reg;
    logic [3:0]         cycle_reg;
    logic               retire_reg;
    logic               halted_reg;
    logic               fault_reg;
    logic [COUNT_W-1:0] count_reg;

`ifdef SEQ_STEP_EN
    logic stepping_reg;
    logic step_ack_reg;
`endif

    // Main sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg      <= IDLE;
            cycle_reg    <= 4'd0;
            retire_reg   <= 1'b0;
            halted_reg   <= 1'b0;
            fault_reg    <= 1'b0;
            count_reg    <= '0;
`ifdef SEQ_STEP_EN
            stepping_reg <= 1'b0;
            step_ack_reg <= 1'b0;
`endif
        end else begin
            retire_reg <= 1'b0;
`ifdef SEQ_STEP_EN
            // Four-phase return: ack drops once the request is seen low
            if (step_ack_reg && !bus.step_req)
                step_ack_reg <= 1'b0;
`endif
            case (fsm_reg)
                IDLE: begin
                    cycle_reg <= 4'd0;
                    if (bus.run) begin
                        fsm_reg <= RUN;
`ifdef SEQ_STEP_EN
                    end else if (bus.step_req && !step_ack_reg) begin
                        fsm_reg      <= RUN;
                        stepping_reg <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (bus.state == STATE_HALT) begin
                        // HLT is not a retirement; cycle freezes where it is
                        fsm_reg    <= HALTED;
                        halted_reg <= 1'b1;
`ifdef SEQ_STEP_EN
                        if (stepping_reg) begin
                            stepping_reg <= 1'b0;
                            step_ack_reg <= 1'b1;
                        end
`endif
                    end else if (bus.state == STATE_NEXT) begin
                        cycle_reg  <= 4'd0;
                        retire_reg <= 1'b1;
                        count_reg  <= count_reg + COUNT_W'(1);
                        // A pause (or end of a single step) only lands here,
                        // so an instruction is never split.
                        if (!bus.run)
                            fsm_reg <= IDLE;
`ifdef SEQ_STEP_EN
                        if (stepping_reg) begin
                            stepping_reg <= 1'b0;
                            step_ack_reg <= 1'b1;
                        end
`endif
                    end else if (cycle_reg == LAST_CYCLE) begin
                        fsm_reg   <= FAULT;
                        fault_reg <= 1'b1;
`ifdef SEQ_STEP_EN
                        if (stepping_reg) begin
                            stepping_reg <= 1'b0;
                            step_ack_reg <= 1'b1;
                        end
`endif
                    end else begin
                        cycle_reg <= cycle_reg + 4'd1;
                    end
                end
                // HALTED and FAULT are sticky: everything holds until reset
                HALTED: fsm_reg <= HALTED;
                FAULT:  fsm_reg <= FAULT;
                default: fsm_reg <= IDLE;
            endcase
        end
    end

    assign bus.cycle      = cycle_reg;
    assign bus.retire     = retire_reg;
    assign bus.halted     = halted_reg;
    assign bus.fault      = fault_reg;
    assign bus.inst_count = count_reg;
`ifdef SEQ_STEP_EN
    assign bus.step_ack   = step_ack_reg;
`else
    assign bus.step_ack   = 1'b0;
`endif
endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer with a stub decoder that reports
// NEXT / HALT at configurable cycle indices.
module tb_cycle_sequencer;
    localparam int         CW         = 4;
    localparam logic [3:0] STATE_NEXT = 4'hE;
    localparam logic [3:0] STATE_HALT = 4'hF;

    logic clk;
    logic reset_n;
    int   next_at;
    int   halt_at;
    int   n_checks;
    int   n_fail;

    cycle_sequencer_if #(.COUNT_W(CW)) bus ();

    cycle_sequencer #(
        .MAX_CYCLE (7),
        .COUNT_W   (CW),
        .STATE_NEXT(STATE_NEXT),
        .STATE_HALT(STATE_HALT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Stub decoder: combinational on the current cycle
    assign bus.state = (int'(bus.cycle) == halt_at) ? STATE_HALT :
                       (int'(bus.cycle) == next_at) ? STATE_NEXT : 4'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int nxt, input int hlt);
        bus.run      = 1'b0;
        bus.step_req = 1'b0;
        next_at      = nxt;
        halt_at      = hlt;
        reset_n      = 1'b0;
        #3;
        reset_n      = 1'b1;
    endtask

    task automatic test_reset();
        bus.run      = 1'b0;
        bus.step_req = 1'b0;
        next_at      = 99;
        halt_at      = 99;
        reset_n      = 1'b0;
        #2;
        n_checks++;
        if (bus.cycle !== 4'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d expected 0", bus.cycle); end
        n_checks++;
        if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b expected 0", bus.retire); end
        n_checks++;
        if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
        n_checks++;
        if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
        n_checks++;
        if (bus.step_ack !== 1'b0) begin n_fail++; $display("FAIL reset_step_ack: got %b expected 0", bus.step_ack); end
        n_checks++;
        if (bus.inst_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.inst_count); end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0) begin n_fail++; $display("FAIL idle_cycle: got %0d expected 0", bus.cycle); end
        $display("test_reset done");
    endtask

    // LDA: NEXT at cycle 6, then reset in the middle of the next one
    task automatic test_lda();
        do_reset(6, 99);
        bus.run = 1'b1;
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0) begin n_fail++; $display("FAIL lda_enter_cycle: got %0d expected 0", bus.cycle); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (bus.cycle !== 4'(k) || bus.retire !== 1'b0) begin
                n_fail++;
                $display("FAIL lda_cycle: got cycle=%0d retire=%b expected cycle=%0d retire=0", bus.cycle, bus.retire, k);
            end
        end
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.retire !== 1'b1 || bus.inst_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lda_boundary: got cycle=%0d retire=%b count=%0d expected 0/1/1", bus.cycle, bus.retire, bus.inst_count);
        end
        tick();
        n_checks++;
        if (bus.cycle !== 4'd1 || bus.retire !== 1'b0 || bus.inst_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lda_after: got cycle=%0d retire=%b count=%0d expected 1/0/1", bus.cycle, bus.retire, bus.inst_count);
        end
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.inst_count !== 4'd0 || bus.retire !== 1'b0) begin
            n_fail++;
            $display("FAIL lda_midreset: got cycle=%0d count=%0d retire=%b expected 0/0/0", bus.cycle, bus.inst_count, bus.retire);
        end
        reset_n = 1'b1;
        $display("test_lda done: one LDA retired, mid-instruction reset");
    endtask

    task automatic test_halt();
        do_reset(99, 2);
        bus.run = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.cycle !== 4'd2 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_pre: got cycle=%0d halted=%b expected 2/0", bus.cycle, bus.halted);
        end
        tick();
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (bus.cycle !== 4'd2 || bus.halted !== 1'b1 || bus.fault !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_frozen: clk %0d got cycle=%0d halted=%b fault=%b expected 2/1/0", k, bus.cycle, bus.halted, bus.fault);
            end
            tick();
        end
        n_checks++;
        if (bus.inst_count !== 4'd0 || bus.retire !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_count: got count=%0d retire=%b expected 0/0", bus.inst_count, bus.retire);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.halted !== 1'b0 || bus.cycle !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got halted=%b cycle=%0d expected 0/0", bus.halted, bus.cycle);
        end
        reset_n = 1'b1;
        $display("test_halt done: frozen at cycle 2");
    endtask

    task automatic test_fault();
        do_reset(99, 99);
        bus.run = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (bus.cycle !== 4'(k) || bus.fault !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_pre: got cycle=%0d fault=%b expected %0d/0", bus.cycle, bus.fault, k);
            end
        end
        tick();
        n_checks++;
        if (bus.fault !== 1'b1 || bus.cycle !== 4'd7) begin
            n_fail++;
            $display("FAIL fault_set: got fault=%b cycle=%0d expected 1/7", bus.fault, bus.cycle);
        end
        tick();
        tick();
        n_checks++;
        if (bus.fault !== 1'b1 || bus.cycle !== 4'd7 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_sticky: got fault=%b cycle=%0d halted=%b expected 1/7/0", bus.fault, bus.cycle, bus.halted);
        end
        $display("test_fault done: overrun trapped at cycle 7");
    endtask

    // ADD (NEXT at 7) with run dropped at cycle 3
    task automatic test_pause();
        do_reset(7, 99);
        bus.run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        n_checks++;
        if (bus.cycle !== 4'd3) begin n_fail++; $display("FAIL pause_at3: got %0d expected 3", bus.cycle); end
        bus.run = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            tick();
            n_checks++;
            if (bus.cycle !== 4'(k) || bus.retire !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_run: got cycle=%0d retire=%b expected %0d/0", bus.cycle, bus.retire, k);
            end
        end
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.retire !== 1'b1 || bus.inst_count !== 4'd1) begin
            n_fail++;
            $display("FAIL pause_boundary: got cycle=%0d retire=%b count=%0d expected 0/1/1", bus.cycle, bus.retire, bus.inst_count);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (bus.cycle !== 4'd0 || bus.retire !== 1'b0 || bus.inst_count !== 4'd1) begin
                n_fail++;
                $display("FAIL pause_idle: got cycle=%0d retire=%b count=%0d expected 0/0/1", bus.cycle, bus.retire, bus.inst_count);
            end
        end
        $display("test_pause done: ADD completed before idling");
    endtask

    // JMP (NEXT at 4) driven by the single-step handshake
    task automatic test_step();
        do_reset(4, 99);
        bus.step_req = 1'b1;
`ifdef SEQ_STEP_EN
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.step_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL step_enter: got cycle=%0d ack=%b expected 0/0", bus.cycle, bus.step_ack);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (bus.cycle !== 4'(k) || bus.step_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL step_run: got cycle=%0d ack=%b expected %0d/0", bus.cycle, bus.step_ack, k);
            end
        end
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.step_ack !== 1'b1 || bus.inst_count !== 4'd1 || bus.retire !== 1'b1) begin
            n_fail++;
            $display("FAIL step_done: got cycle=%0d ack=%b count=%0d retire=%b expected 0/1/1/1", bus.cycle, bus.step_ack, bus.inst_count, bus.retire);
        end
        tick();
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.step_ack !== 1'b1 || bus.inst_count !== 4'd1) begin
            n_fail++;
            $display("FAIL step_hold: got cycle=%0d ack=%b count=%0d expected 0/1/1", bus.cycle, bus.step_ack, bus.inst_count);
        end
        bus.step_req = 1'b0;
        tick();
        n_checks++;
        if (bus.step_ack !== 1'b0) begin n_fail++; $display("FAIL step_release: got ack=%b expected 0", bus.step_ack); end
        tick();
        n_checks++;
        if (bus.cycle !== 4'd0 || bus.inst_count !== 4'd1) begin
            n_fail++;
            $display("FAIL step_idle: got cycle=%0d count=%0d expected 0/1", bus.cycle, bus.inst_count);
        end
        $display("test_step done: one JMP stepped and acknowledged");
`else
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (bus.cycle !== 4'd0 || bus.step_ack !== 1'b0 || bus.inst_count !== 4'd0) begin
                n_fail++;
                $display("FAIL step_disabled: got cycle=%0d ack=%b count=%0d expected 0/0/0", bus.cycle, bus.step_ack, bus.inst_count);
            end
        end
        bus.step_req = 1'b0;
        $display("test_step done: step request ignored");
`endif
    endtask

    // 17 back-to-back OUT instructions into a 4-bit counter
    task automatic test_back_to_back();
        do_reset(3, 99);
        bus.run = 1'b1;
        tick();
        for (int k = 0; k < 64; k++) tick();
        n_checks++;
        if (bus.inst_count !== 4'd0 || bus.retire !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap16: got count=%0d retire=%b expected 0/1", bus.inst_count, bus.retire);
        end
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if (bus.inst_count !== 4'd1 || bus.retire !== 1'b1 || bus.cycle !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap17: got count=%0d retire=%b cycle=%0d expected 1/1/0", bus.inst_count, bus.retire, bus.cycle);
        end
        bus.run = 1'b0;
        $display("test_back_to_back done: 17 OUT instructions");
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        bus.run      = 1'b0;
        bus.step_req = 1'b0;
        next_at      = 99;
        halt_at      = 99;
        test_reset();
        test_lda();
        test_halt();
        test_fault();
        test_pause();
        test_step();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
